// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - sprite ROM arbiter with pixel priority, round-robin, tagged return, starvation flags
module sprite_rom_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int AW       = 13,
  parameter int DW       = 3,
  parameter int ROM_LAT  = 1,
  parameter int MAX_WAIT = 64
) (
  input  logic                    vga_clk,
  input  logic                    reset_n,
  input  logic                    blank,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*AW-1:0]   addr,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [AW-1:0]           rom_addr,
  output logic                    rom_rd,
  input  logic [DW-1:0]           rom_q,
  output logic [NUM_REQ-1:0]      rvalid,
  output logic [DW-1:0]           rdata,
  output logic [NUM_REQ-1:0]      starve,
  input  logic                    starve_clr
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_WAIT + 1);

  // Round-robin pointer: index of the last requester served by the rotating search
  logic [IW-1:0]      r_rr_ptr;

  // Return-path tag pipe, one {valid, index} entry per cycle of ROM latency
  logic               r_tag_vld [ROM_LAT];
  logic [IW-1:0]      r_tag_idx [ROM_LAT];

  // Starvation bookkeeping
  logic [CW-1:0]      r_wait_cnt [NUM_REQ];
  logic [NUM_REQ-1:0] r_starve;

  // Arbitration results
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_gnt_any;
  logic               w_rr_gnt;
  logic [IW-1:0]      w_gnt_idx;
  logic [IW:0]        w_sum;
  logic [IW-1:0]      w_scan_idx;
  logic [NUM_REQ-1:0] w_starve_set;

  // Grant selection: pixel pipe wins while visible, otherwise rotate from rr_ptr+1
  always_comb begin
    w_gnt      = '0;
    w_gnt_any  = 1'b0;
    w_rr_gnt   = 1'b0;
    w_gnt_idx  = '0;
    w_sum      = '0;
    w_scan_idx = '0;
    if (reset_n) begin
      if (blank && req[0]) begin
        w_gnt[0]  = 1'b1;
        w_gnt_any = 1'b1;
      end else begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          w_sum = {1'b0, r_rr_ptr} + (IW+1)'(k);
          if (w_sum >= (IW+1)'(NUM_REQ)) begin
            w_sum = w_sum - (IW+1)'(NUM_REQ);
          end
          w_scan_idx = w_sum[IW-1:0];
          if (!w_gnt_any && req[w_scan_idx]) begin
            w_gnt[w_scan_idx] = 1'b1;
            w_gnt_idx         = w_scan_idx;
            w_gnt_any         = 1'b1;
            w_rr_gnt          = 1'b1;
          end
        end
      end
    end
  end

  assign gnt    = w_gnt;
  assign rom_rd = w_gnt_any;

  // ROM address mux: address of the granted requester, zero when idle
  always_comb begin
    rom_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        rom_addr = addr[i*AW +: AW];
      end
    end
  end

  // Pointer advances only on rotating grants; priority grants leave fairness untouched
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr <= IW'(NUM_REQ - 1);
    end else if (w_rr_gnt) begin
      r_rr_ptr <= w_gnt_idx;
    end
  end

  // Tag pipe shifts every cycle so returns line up with the ROM's fixed latency
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < ROM_LAT; s++) begin
        r_tag_vld[s] <= 1'b0;
        r_tag_idx[s] <= '0;
      end
    end else begin
      r_tag_vld[0] <= w_gnt_any;
      r_tag_idx[0] <= w_gnt_idx;
      for (int s = 1; s < ROM_LAT; s++) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
        r_tag_idx[s] <= r_tag_idx[s-1];
      end
    end
  end

  // Decode the oldest tag into a one-hot return strobe
  always_comb begin
    rvalid = '0;
    if (reset_n && r_tag_vld[ROM_LAT-1]) begin
      rvalid[r_tag_idx[ROM_LAT-1]] = 1'b1;
    end
  end

  assign rdata = rom_q;

  // A waiting requester becomes starved on the edge its count reaches MAX_WAIT
  always_comb begin
    w_starve_set = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_starve_set[i] = req[i] && !w_gnt[i] && (r_wait_cnt[i] >= CW'(MAX_WAIT - 1));
    end
  end

  // Wait counters: count unserved cycles, saturate, restart on grant or withdrawal
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_wait_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req[i] || w_gnt[i]) begin
          r_wait_cnt[i] <= '0;
        end else if (r_wait_cnt[i] != CW'(MAX_WAIT)) begin
          r_wait_cnt[i] <= r_wait_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Sticky starvation flags; a fresh set overrides a simultaneous clear
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve <= '0;
    end else begin
      r_starve <= (starve_clr ? '0 : r_starve) | w_starve_set;
    end
  end

  assign starve = r_starve;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb/tb_sprite_rom_arbiter.sv - directed self-checking bench for sprite_rom_arbiter
module tb_sprite_rom_arbiter;

  localparam int NR = 4;
  localparam int AW = 13;
  localparam int DW = 3;

  logic vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic             reset_n;
  logic             blank;
  logic             starve_clr;
  logic [NR-1:0]    req;
  logic [NR*AW-1:0] addr;

  logic [NR-1:0] gnt1, rvalid1, starve1;
  logic [AW-1:0] rom_addr1;
  logic          rom_rd1;
  logic [DW-1:0] rom_q1, rdata1;

  logic [NR-1:0] gnt3, rvalid3, starve3;
  logic [AW-1:0] rom_addr3;
  logic          rom_rd3;
  logic [DW-1:0] rom_q3, rdata3, q3_s0, q3_s1;

  logic [AW-1:0] a [NR];

  int errors = 0;
  int checks = 0;

  sprite_rom_arbiter #(.NUM_REQ(NR), .AW(AW), .DW(DW), .ROM_LAT(1), .MAX_WAIT(64)) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .blank(blank), .req(req), .addr(addr),
    .gnt(gnt1), .rom_addr(rom_addr1), .rom_rd(rom_rd1), .rom_q(rom_q1),
    .rvalid(rvalid1), .rdata(rdata1), .starve(starve1), .starve_clr(starve_clr)
  );

  sprite_rom_arbiter #(.NUM_REQ(NR), .AW(AW), .DW(DW), .ROM_LAT(3), .MAX_WAIT(64)) dut3 (
    .vga_clk(vga_clk), .reset_n(reset_n), .blank(blank), .req(req), .addr(addr),
    .gnt(gnt3), .rom_addr(rom_addr3), .rom_rd(rom_rd3), .rom_q(rom_q3),
    .rvalid(rvalid3), .rdata(rdata3), .starve(starve3), .starve_clr(starve_clr)
  );

  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] x);
    return x[2:0] ^ x[5:3] ^ x[12:10];
  endfunction

  // ROM models with 1- and 3-cycle latency
  always @(posedge vga_clk) rom_q1 <= rom_f(rom_addr1);
  always @(posedge vga_clk) begin
    q3_s0  <= rom_f(rom_addr3);
    q3_s1  <= q3_s0;
    rom_q3 <= q3_s1;
  end

  task automatic load_addrs();
    addr = {a[3], a[2], a[1], a[0]};
  endtask

  task automatic do_reset();
    @(negedge vga_clk);
    reset_n = 1'b0; req = '0; blank = 1'b0; starve_clr = 1'b0; addr = '0;
    repeat (2) @(negedge vga_clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge vga_clk);
    reset_n = 1'b0; req = 4'b1111; blank = 1'b1;
    a[0] = 13'h0123; a[1] = 13'h0456; a[2] = 13'h0789; a[3] = 13'h0ABC;
    load_addrs();
    #1;
    checks++; if (gnt1 !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt1); end
    checks++; if (rom_rd1 !== 1'b0) begin errors++; $display("FAIL reset_rom_rd: got %b expected 0", rom_rd1); end
    checks++; if (rom_addr1 !== 13'h0) begin errors++; $display("FAIL reset_rom_addr: got %h expected 0000", rom_addr1); end
    checks++; if (rvalid1 !== 4'b0000) begin errors++; $display("FAIL reset_rvalid: got %b expected 0000", rvalid1); end
    @(negedge vga_clk); #1;
    checks++; if (starve1 !== 4'b0000) begin errors++; $display("FAIL reset_starve: got %b expected 0000", starve1); end
    checks++; if (gnt3 !== 4'b0000) begin errors++; $display("FAIL reset_gnt3: got %b expected 0000", gnt3); end
  endtask

  task automatic test_single();
    do_reset();
    a[0] = 13'h0; a[1] = 13'h0155; a[2] = 13'h0; a[3] = 13'h0;
    load_addrs();
    req = 4'b0010;
    #1;
    checks++; if (gnt1 !== 4'b0010) begin errors++; $display("FAIL single_gnt: got %b expected 0010", gnt1); end
    checks++; if (rom_addr1 !== 13'h0155) begin errors++; $display("FAIL single_rom_addr: got %h expected 0155", rom_addr1); end
    checks++; if (rom_rd1 !== 1'b1) begin errors++; $display("FAIL single_rom_rd: got %b expected 1", rom_rd1); end
    checks++; if (rvalid1 !== 4'b0000) begin errors++; $display("FAIL single_rvalid_early: got %b expected 0000", rvalid1); end
    @(negedge vga_clk);
    req = 4'b0000;
    #1;
    checks++; if (rvalid1 !== 4'b0010) begin errors++; $display("FAIL single_rvalid: got %b expected 0010", rvalid1); end
    checks++; if (rdata1 !== rom_f(13'h0155)) begin errors++; $display("FAIL single_rdata: got %h expected %h", rdata1, rom_f(13'h0155)); end
    checks++; if (rom_rd1 !== 1'b0) begin errors++; $display("FAIL single_idle_rd: got %b expected 0", rom_rd1); end
    @(negedge vga_clk); #1;
    checks++; if (rvalid1 !== 4'b0000) begin errors++; $display("FAIL single_rvalid_late: got %b expected 0000", rvalid1); end
  endtask

  task automatic test_priority();
    logic [NR-1:0] exp_seq [4];
    exp_seq[0] = 4'b0010; exp_seq[1] = 4'b0100; exp_seq[2] = 4'b1000; exp_seq[3] = 4'b0010;
    do_reset();
    a[0] = 13'h0100; a[1] = 13'h00A3; a[2] = 13'h01C7; a[3] = 13'h02F5;
    load_addrs();
    blank = 1'b1;
    req = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++; if (gnt1 !== 4'b0001) begin errors++; $display("FAIL prio_gnt c=%0d: got %b expected 0001", c, gnt1); end
      checks++; if (rom_addr1 !== a[0]) begin errors++; $display("FAIL prio_addr c=%0d: got %h expected %h", c, rom_addr1, a[0]); end
      @(negedge vga_clk);
    end
    #1;
    checks++; if (starve1 !== 4'b0000) begin errors++; $display("FAIL prio_starve: got %b expected 0000", starve1); end
    req = 4'b1110;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (gnt1 !== exp_seq[c]) begin errors++; $display("FAIL prio_rr c=%0d: got %b expected %b", c, gnt1, exp_seq[c]); end
      @(negedge vga_clk);
    end
    req = 4'b0000;
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] exp_g;
    logic [NR-1:0] prev_g;
    logic [AW-1:0] prev_a;
    do_reset();
    a[0] = 13'h1A01; a[1] = 13'h0B12; a[2] = 13'h0C2B; a[3] = 13'h1D3C;
    load_addrs();
    blank = 1'b0;
    req = 4'b1111;
    prev_g = '0;
    prev_a = '0;
    for (int c = 0; c < 5; c++) begin
      exp_g = 4'b0001 << (c % 4);
      #1;
      checks++; if (gnt1 !== exp_g) begin errors++; $display("FAIL rr_gnt c=%0d: got %b expected %b", c, gnt1, exp_g); end
      checks++; if (rom_addr1 !== a[c % 4]) begin errors++; $display("FAIL rr_addr c=%0d: got %h expected %h", c, rom_addr1, a[c % 4]); end
      if (c > 0) begin
        checks++; if (rvalid1 !== prev_g) begin errors++; $display("FAIL rr_rvalid c=%0d: got %b expected %b", c, rvalid1, prev_g); end
        checks++; if (rdata1 !== rom_f(prev_a)) begin errors++; $display("FAIL rr_rdata c=%0d: got %h expected %h", c, rdata1, rom_f(prev_a)); end
      end
      prev_g = exp_g;
      prev_a = a[c % 4];
      @(negedge vga_clk);
    end
    req = 4'b0000;
    #1;
    checks++; if (rvalid1 !== prev_g) begin errors++; $display("FAIL rr_rvalid_last: got %b expected %b", rvalid1, prev_g); end
    checks++; if (rdata1 !== rom_f(prev_a)) begin errors++; $display("FAIL rr_rdata_last: got %h expected %h", rdata1, rom_f(prev_a)); end
  endtask

  task automatic test_starvation();
    do_reset();
    a[0] = 13'h0011; a[1] = 13'h0; a[2] = 13'h0022; a[3] = 13'h0;
    load_addrs();
    blank = 1'b1;
    req = 4'b0101;
    for (int n = 1; n <= 64; n++) begin
      @(negedge vga_clk); #1;
      if (n == 1) begin
        checks++; if (gnt1 !== 4'b0001) begin errors++; $display("FAIL starve_gnt: got %b expected 0001", gnt1); end
      end
      if (n == 63) begin
        checks++; if (starve1 !== 4'b0000) begin errors++; $display("FAIL starve_early: got %b expected 0000", starve1); end
      end
      if (n == 64) begin
        checks++; if (starve1 !== 4'b0100) begin errors++; $display("FAIL starve_set: got %b expected 0100", starve1); end
      end
    end
    starve_clr = 1'b1;
    @(negedge vga_clk);
    starve_clr = 1'b0;
    #1;
    checks++; if (starve1 !== 4'b0100) begin errors++; $display("FAIL starve_set_wins: got %b expected 0100", starve1); end
    req = 4'b0000;
    starve_clr = 1'b1;
    @(negedge vga_clk);
    starve_clr = 1'b0;
    #1;
    checks++; if (starve1 !== 4'b0000) begin errors++; $display("FAIL starve_clear: got %b expected 0000", starve1); end
    @(negedge vga_clk); #1;
    checks++; if (starve1 !== 4'b0000) begin errors++; $display("FAIL starve_stays_clear: got %b expected 0000", starve1); end
  endtask

  task automatic test_back_to_back_lat3();
    logic [NR-1:0] exp_v;
    do_reset();
    a[0] = 13'h0E07; a[1] = 13'h1238; a[2] = 13'h0451; a[3] = 13'h1F2A;
    load_addrs();
    blank = 1'b0;
    req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      if (c == 4) req = 4'b0000;
      #1;
      exp_v = (c >= 3 && c <= 6) ? (4'b0001 << (c - 3)) : 4'b0000;
      if (c < 4) begin
        checks++; if (gnt3 !== (4'b0001 << c)) begin errors++; $display("FAIL lat3_gnt c=%0d: got %b expected %b", c, gnt3, 4'b0001 << c); end
      end
      checks++; if (rvalid3 !== exp_v) begin errors++; $display("FAIL lat3_rvalid c=%0d: got %b expected %b", c, rvalid3, exp_v); end
      if (c >= 3 && c <= 6) begin
        checks++; if (rdata3 !== rom_f(a[c-3])) begin errors++; $display("FAIL lat3_rdata c=%0d: got %h expected %h", c, rdata3, rom_f(a[c-3])); end
      end
      @(negedge vga_clk);
    end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    a[0] = 13'h0011; a[1] = 13'h00AB; a[2] = 13'h0333; a[3] = 13'h0444;
    load_addrs();
    blank = 1'b0;
    req = 4'b0010;
    #1;
    checks++; if (gnt3 !== 4'b0010) begin errors++; $display("FAIL inflight_gnt: got %b expected 0010", gnt3); end
    @(negedge vga_clk);
    req = 4'b0000;
    #1;
    checks++; if (rvalid1 !== 4'b0010) begin errors++; $display("FAIL inflight_rvalid1_pre: got %b expected 0010", rvalid1); end
    reset_n = 1'b0;
    req = 4'b0001;
    #1;
    checks++; if (rvalid1 !== 4'b0000) begin errors++; $display("FAIL inflight_rvalid1_rst: got %b expected 0000", rvalid1); end
    checks++; if (gnt3 !== 4'b0000) begin errors++; $display("FAIL inflight_gnt_rst: got %b expected 0000", gnt3); end
    checks++; if (rom_rd3 !== 1'b0) begin errors++; $display("FAIL inflight_rd_rst: got %b expected 0", rom_rd3); end
    @(negedge vga_clk);
    reset_n = 1'b1;
    #1;
    checks++; if (gnt3 !== 4'b0001) begin errors++; $display("FAIL post_rst_gnt: got %b expected 0001", gnt3); end
    checks++; if (rvalid3 !== 4'b0000) begin errors++; $display("FAIL post_rst_rvalid r0: got %b expected 0000", rvalid3); end
    @(negedge vga_clk);
    req = 4'b1111;
    #1;
    checks++; if (gnt3 !== 4'b0010) begin errors++; $display("FAIL post_rst_rr: got %b expected 0010", gnt3); end
    checks++; if (rvalid3 !== 4'b0000) begin errors++; $display("FAIL post_rst_rvalid r1: got %b expected 0000", rvalid3); end
    checks++; if (rvalid1 !== 4'b0001) begin errors++; $display("FAIL post_rst_rvalid1: got %b expected 0001", rvalid1); end
    @(negedge vga_clk);
    req = 4'b0000;
    #1;
    checks++; if (rvalid3 !== 4'b0000) begin errors++; $display("FAIL post_rst_rvalid r2: got %b expected 0000", rvalid3); end
    @(negedge vga_clk); #1;
    checks++; if (rvalid3 !== 4'b0001) begin errors++; $display("FAIL post_rst_rvalid r3: got %b expected 0001", rvalid3); end
    @(negedge vga_clk); #1;
    checks++; if (rvalid3 !== 4'b0010) begin errors++; $display("FAIL post_rst_rvalid r4: got %b expected 0010", rvalid3); end
    @(negedge vga_clk); #1;
    checks++; if (rvalid3 !== 4'b0000) begin errors++; $display("FAIL post_rst_rvalid r5: got %b expected 0000", rvalid3); end
  endtask

  initial begin
    reset_n = 1'b0; req = '0; blank = 1'b0; starve_clr = 1'b0; addr = '0;
    test_reset();
    test_single();
    test_priority();
    test_round_robin();
    test_starvation();
    test_back_to_back_lat3();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
